// File: rtl/bus_if_pkg.sv
// Shared types and encodings for the memory-side bus interface of the 6502 core.
// Holds the FSM state type, the RW encodings and the launch condition helper.
package bus_if_pkg;

   typedef enum logic [1:0] {
      BIF_IDLE   = 2'd0,
      BIF_ACCESS = 2'd1,
      BIF_RESP   = 2'd2
   } bif_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // RDY only holds off reads; writes launch regardless of RDY.
   function automatic logic is_launch(input logic cyc_valid, input logic rw, input logic rdy);
      return cyc_valid && ((rw == RW_WRITE) || rdy);
   endfunction

endpackage

// File: rtl/bus_if_if.sv
// Bundle of core-side and memory-side signals around bus_if.
// slave = the bus_if block itself; master = core datapath plus memory.
interface bus_if_if;
   logic        cyc_valid;
   logic        rw;
   logic        rdy;
   logic [7:0]  abl;
   logic [7:0]  abh;
   logic [7:0]  db_out;
   logic [7:0]  db_in;
   logic        stall;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   modport slave (
      input  cyc_valid, rw, rdy, abl, abh, db_out, mem_ack, mem_rdata,
      output db_in, stall, bus_err, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cyc_valid, rw, rdy, abl, abh, db_out, mem_ack, mem_rdata,
      input  db_in, stall, bus_err, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/bus_if_timer.sv
// Access wait timer: 8-bit counter with clear and enable that saturates one below
// LIMIT and flags EXPIRE there. LIMIT = 0 disables expiry and saturates at 8'hff.
module bus_if_timer (
   input  logic       clk,
   input  logic       res,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] limit,
   output logic       expire
);

   logic [7:0] count_reg;
   logic [7:0] sat_value;

   assign sat_value = (limit == 8'd0) ? 8'hff : limit - 8'd1;
   assign expire    = (limit != 8'd0) && (count_reg == sat_value);

   always_ff @(posedge clk) begin
      if (res || clr) begin
         count_reg <= 8'd0;
      end else if (en && (count_reg != sat_value)) begin
         count_reg <= count_reg + 8'd1;
      end
   end

endmodule

// File: rtl/bus_if.sv
// REQ/ACK bridge from the 6502 datapath to variable-latency memory. Stalls the core
// while an access is outstanding and returns read data as DB_IN on the release cycle.
module bus_if
   import bus_if_pkg::*;
#(
   parameter logic [7:0] P_DB_IN_INIT = 8'h00,
   parameter logic [7:0] P_TIMEOUT    = 8'd16,
   parameter logic [7:0] P_ERR_DATA   = 8'hff
) (
   input  logic     clk,
   input  logic     res,
   bus_if_if.slave  bus
);

   bif_state_t  state_reg, state_next;
   logic        mem_req_reg, mem_req_next;
   logic        mem_we_reg, mem_we_next;
   logic        bus_err_reg, bus_err_next;
   logic [15:0] mem_addr_reg, mem_addr_next;
   logic [7:0]  mem_wdata_reg, mem_wdata_next;
   logic [7:0]  db_in_reg, db_in_next;
   logic        launch;
   logic        timer_clr;
   logic        timer_en;
   logic        timer_expire;
   logic        stall;

   assign launch    = (state_reg == BIF_IDLE) && is_launch(bus.cyc_valid, bus.rw, bus.rdy);
   assign timer_clr = launch;
   assign timer_en  = (state_reg == BIF_ACCESS) && !bus.mem_ack;

   bus_if_timer u_timer (
      .clk    (clk),
      .res    (res),
      .clr    (timer_clr),
      .en     (timer_en),
      .limit  (P_TIMEOUT),
      .expire (timer_expire)
   );

   always_ff @(posedge clk) begin
      if (res) begin
         state_reg     <= BIF_IDLE;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         bus_err_reg   <= 1'b0;
         mem_addr_reg  <= 16'h0000;
         mem_wdata_reg <= 8'h00;
         db_in_reg     <= P_DB_IN_INIT;
      end else begin
         state_reg     <= state_next;
         mem_req_reg   <= mem_req_next;
         mem_we_reg    <= mem_we_next;
         bus_err_reg   <= bus_err_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         db_in_reg     <= db_in_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      mem_req_next   = mem_req_reg;
      mem_we_next    = mem_we_reg;
      bus_err_next   = bus_err_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      db_in_next     = db_in_reg;

      case (state_reg)
         BIF_IDLE: begin
            if (launch) begin
               mem_addr_next  = {bus.abh, bus.abl};
               mem_wdata_next = bus.db_out;
               mem_we_next    = (bus.rw == RW_WRITE);
               mem_req_next   = 1'b1;
               state_next     = BIF_ACCESS;
            end
         end
         BIF_ACCESS: begin
            // An ACK arriving on the expiry cycle still completes normally.
            if (bus.mem_ack) begin
               if (!mem_we_reg) begin
                  db_in_next = bus.mem_rdata;
               end
               mem_req_next = 1'b0;
               state_next   = BIF_RESP;
            end else if (timer_expire) begin
               if (!mem_we_reg) begin
                  db_in_next = P_ERR_DATA;
               end
               mem_req_next = 1'b0;
               bus_err_next = 1'b1;
               state_next   = BIF_RESP;
            end
         end
         BIF_RESP: begin
            state_next = BIF_IDLE;
         end
         default: begin
            state_next   = BIF_IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   // RESP is the single release cycle in which the core advances.
   always_comb begin
      stall = 1'b0;
      if (!res) begin
         case (state_reg)
            BIF_IDLE:   stall = bus.cyc_valid;
            BIF_ACCESS: stall = 1'b1;
            default:    stall = 1'b0;
         endcase
      end
   end

   assign bus.stall     = stall;
   assign bus.db_in     = db_in_reg;
   assign bus.bus_err   = bus_err_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_bus_if.sv
// Directed bench for bus_if: a scoreboard of expected transactions is filled as each
// request is driven and drained on the release cycle.
module tb_bus_if;
   import bus_if_pkg::*;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic [7:0]  db_in;
      logic        err;
   } txn_t;

   logic clk = 1'b0;
   logic res = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   txn_t sb[$];
   logic [7:0] model_db;
   logic       model_err;

   always #5 clk = ~clk;

   bus_if_if bus ();

   bus_if #(
      .P_DB_IN_INIT (8'h00),
      .P_TIMEOUT    (8'd4),
      .P_ERR_DATA   (8'hff)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access starting in IDLE. waits = ACCESS cycles before the last one;
   // ack = 0 lets the timer expire. hold keeps CYC_VALID high through RESP.
   task automatic access(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                         input int waits, input logic ack, input logic [7:0] rdata,
                         input logic rdy_in, input logic hold);
      txn_t t;
      bus.cyc_valid = 1'b1;
      bus.rw        = rw;
      bus.rdy       = rdy_in;
      bus.abh       = addr[15:8];
      bus.abl       = addr[7:0];
      bus.db_out    = wdata;
      bus.mem_ack   = 1'b0;
      #1;
      check("idle_stall", 16'(bus.stall), 16'd1);
      check("idle_req", 16'(bus.mem_req), 16'd0);
      if (ack) begin
         if (rw == RW_READ) model_db = rdata;
      end else begin
         model_err = 1'b1;
         if (rw == RW_READ) model_db = 8'hff;
      end
      t = '{addr, (rw == RW_WRITE), wdata, model_db, model_err};
      sb.push_back(t);
      tick();
      bus.abh    = ~addr[15:8];
      bus.abl    = ~addr[7:0];
      bus.db_out = ~wdata;
      bus.rw     = ~rw;
      for (int i = 0; i <= waits; i++) begin
         check("acc_req", 16'(bus.mem_req), 16'd1);
         check("acc_stall", 16'(bus.stall), 16'd1);
         check("acc_addr", bus.mem_addr, sb[0].addr);
         check("acc_we", 16'(bus.mem_we), 16'(sb[0].we));
         check("acc_wdata", 16'(bus.mem_wdata), 16'(sb[0].wdata));
         bus.mem_ack   = ack && (i == waits);
         bus.mem_rdata = (i == waits) ? rdata : 8'h3c;
         tick();
      end
      bus.mem_ack = 1'b0;
      if (!hold) bus.cyc_valid = 1'b0;
      #1;
      check("resp_stall", 16'(bus.stall), 16'd0);
      check("resp_req", 16'(bus.mem_req), 16'd0);
      check("sb_nonempty", 16'(sb.size()), 16'd1);
      if (sb.size() > 0) begin
         t = sb.pop_front();
         check("resp_db_in", 16'(bus.db_in), 16'(t.db_in));
         check("resp_bus_err", 16'(bus.bus_err), 16'(t.err));
         $display("txn %s addr=%h wdata=%h db_in=%h bus_err=%0b",
                  t.we ? "write" : "read ", t.addr, t.wdata, bus.db_in, bus.bus_err);
      end
      tick();
      check("post_req", 16'(bus.mem_req), 16'd0);
      check("post_stall", 16'(bus.stall), 16'(hold));
   endtask

   initial begin
      bus.cyc_valid = 1'b1;
      bus.rw        = RW_READ;
      bus.rdy       = 1'b1;
      bus.abh       = 8'h00;
      bus.abl       = 8'h00;
      bus.db_out    = 8'h00;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      model_db      = 8'h00;
      model_err     = 1'b0;
      res           = 1'b1;
      tick();
      tick();
      check("rst_stall", 16'(bus.stall), 16'd0);
      check("rst_req", 16'(bus.mem_req), 16'd0);
      check("rst_we", 16'(bus.mem_we), 16'd0);
      check("rst_err", 16'(bus.bus_err), 16'd0);
      check("rst_db_in", 16'(bus.db_in), 16'h00);
      check("rst_addr", bus.mem_addr, 16'h0000);
      check("rst_wdata", 16'(bus.mem_wdata), 16'h00);
      res = 1'b0;
      bus.cyc_valid = 1'b0;
      tick();
      check("idle0_stall", 16'(bus.stall), 16'd0);
      check("idle0_req", 16'(bus.mem_req), 16'd0);

      // Zero-wait read, then a write whose ACK lands on the timer expiry cycle.
      access(RW_READ, 16'h1234, 8'h00, 0, 1'b1, 8'ha9, 1'b1, 1'b0);
      access(RW_WRITE, 16'h0200, 8'h5a, 3, 1'b1, 8'h77, 1'b1, 1'b0);

      // RDY low holds off a read without launching.
      bus.cyc_valid = 1'b1;
      bus.rw        = RW_READ;
      bus.rdy       = 1'b0;
      bus.abh       = 8'h40;
      bus.abl       = 8'h10;
      #1;
      check("rdy_stall0", 16'(bus.stall), 16'd1);
      tick();
      check("rdy_req1", 16'(bus.mem_req), 16'd0);
      check("rdy_stall1", 16'(bus.stall), 16'd1);
      tick();
      check("rdy_req2", 16'(bus.mem_req), 16'd0);
      access(RW_READ, 16'h4010, 8'h00, 1, 1'b1, 8'hc3, 1'b1, 1'b0);
      access(RW_WRITE, 16'h4011, 8'h96, 0, 1'b1, 8'h00, 1'b0, 1'b0);

      // Timeout on a read, then a good read leaves BUS_ERR set.
      access(RW_READ, 16'hbeef, 8'h00, 3, 1'b0, 8'h00, 1'b1, 1'b0);
      access(RW_READ, 16'h0001, 8'h00, 2, 1'b1, 8'h42, 1'b1, 1'b0);

      // Reset in the middle of an access, followed by a late ACK.
      bus.cyc_valid = 1'b1;
      bus.rw        = RW_READ;
      bus.rdy       = 1'b1;
      bus.abh       = 8'h55;
      bus.abl       = 8'h66;
      tick();
      check("mid_req", 16'(bus.mem_req), 16'd1);
      res = 1'b1;
      tick();
      check("mid_rst_req", 16'(bus.mem_req), 16'd0);
      check("mid_rst_stall", 16'(bus.stall), 16'd0);
      check("mid_rst_db_in", 16'(bus.db_in), 16'h00);
      check("mid_rst_err", 16'(bus.bus_err), 16'd0);
      res = 1'b0;
      bus.cyc_valid = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h77;
      tick();
      bus.mem_ack = 1'b0;
      check("late_ack_db_in", 16'(bus.db_in), 16'h00);
      check("late_ack_req", 16'(bus.mem_req), 16'd0);
      model_db  = 8'h00;
      model_err = 1'b0;

      // Back-to-back reads with CYC_VALID held through RESP, then idle cycles.
      access(RW_READ, 16'h0300, 8'h00, 0, 1'b1, 8'h11, 1'b1, 1'b1);
      access(RW_READ, 16'h0301, 8'h00, 1, 1'b1, 8'h22, 1'b1, 1'b1);
      access(RW_READ, 16'h0302, 8'h00, 0, 1'b1, 8'h33, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_run_stall", 16'(bus.stall), 16'd0);
         check("idle_run_req", 16'(bus.mem_req), 16'd0);
      end
      check("final_db_in", 16'(bus.db_in), 16'h33);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
